gj_axis_uart_regs_mc: RTL

GJ_AXIS_UART_REGS_MC -- requirements
Module: gj_axis_uart_regs_mc

---
 rtl/gj_uart_regs_pkg.sv | 36 +++
 rtl/gj_uart_chan_regs.sv | 167 ++++++++++++++++
 rtl/gj_axis_uart_regs_mc.sv | 85 ++++++++
 3 files changed

// File: rtl/gj_uart_regs_pkg.sv
// Shared constants for the multi-channel UART register block: the register map,
// the INT_STAT bit positions and the configuration field widths.
package gj_uart_regs_pkg;

    localparam int CHANNELS_MAX = 8;

    localparam int CH_W   = 3;
    localparam int REG_W  = 4;
    localparam int DATA_W = 32;
    localparam int MODE_W = 4;
    localparam int DIV_W  = 16;
    localparam int NOP_W  = 16;
    localparam int GAP_W  = 16;
    localparam int MAXB_W = 24;
    localparam int INT_W  = 5;
    localparam int N_CNT  = 4;

    localparam logic [REG_W-1:0] REG_CTRL      = 4'd0;
    localparam logic [REG_W-1:0] REG_NOP       = 4'd1;
    localparam logic [REG_W-1:0] REG_GAP       = 4'd2;
    localparam logic [REG_W-1:0] REG_MAXB      = 4'd3;
    localparam logic [REG_W-1:0] REG_TX_BYTES  = 4'd4;
    localparam logic [REG_W-1:0] REG_RX_BYTES  = 4'd5;
    localparam logic [REG_W-1:0] REG_RX_ERR    = 4'd6;
    localparam logic [REG_W-1:0] REG_START_ERR = 4'd7;
    localparam logic [REG_W-1:0] REG_INT_STAT  = 4'd8;
    localparam logic [REG_W-1:0] REG_INT_EN    = 4'd9;
    localparam logic [REG_W-1:0] REG_CNT_CLR   = 4'd10;

    localparam int INT_TX        = 0;
    localparam int INT_RX        = 1;
    localparam int INT_RX_ERR    = 2;
    localparam int INT_START_ERR = 3;
    localparam int INT_SAT       = 4;

endpackage

// File: rtl/gj_uart_chan_regs.sv
// One UART channel: configuration registers, saturating event counters,
// sticky interrupt status with W1C and a registered interrupt line.
module gj_uart_chan_regs
    import gj_uart_regs_pkg::*;
#(
    parameter int               CNT_W   = 32,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd54253
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic [REG_W-1:0]    reg_idx,
    input  logic [3:0]          we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                soft_rst,
    input  logic                tx_bytes_int,
    input  logic                rx_bytes_int,
    input  logic                rx_bytes_error,
    input  logic                start_error,
    output logic                power_down,
    output logic [MODE_W-1:0]   mode,
    output logic [DIV_W-1:0]    clk_div,
    output logic [NOP_W-1:0]    tx_byte_nop,
    output logic [NOP_W-1:0]    tx_frame_nop,
    output logic [GAP_W-1:0]    max_rcv_gap,
    output logic [MAXB_W-1:0]   max_bytes,
    output logic [DATA_W-1:0]   rdata,
    output logic                irq
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_SAT_M1 = ~CNT_ONE;

    logic                power_down_q, power_down_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [DIV_W-1:0]    clk_div_q, clk_div_d;
    logic [NOP_W-1:0]    tx_byte_nop_q, tx_byte_nop_d;
    logic [NOP_W-1:0]    tx_frame_nop_q, tx_frame_nop_d;
    logic [GAP_W-1:0]    max_rcv_gap_q, max_rcv_gap_d;
    logic [MAXB_W-1:0]   max_bytes_q, max_bytes_d;
    logic [INT_W-1:0]    int_stat_q, int_stat_d;
    logic [INT_W-1:0]    int_en_q, int_en_d;
    logic                irq_q, irq_d;
    logic [CNT_W-1:0]    cnt_q [N_CNT];
    logic [CNT_W-1:0]    cnt_d [N_CNT];

    logic [N_CNT-1:0]    cnt_inc;
    logic [N_CNT-1:0]    cnt_clr;
    logic [INT_W-1:0]    w1c;
    logic                sat_hit;

    // Counter order matches the CNT_CLR bit order and the read offsets 4..7.
    assign cnt_inc = {start_error, rx_bytes_int & rx_bytes_error, rx_bytes_int, tx_bytes_int};

    always_comb begin
        power_down_d   = power_down_q;
        mode_d         = mode_q;
        clk_div_d      = clk_div_q;
        tx_byte_nop_d  = tx_byte_nop_q;
        tx_frame_nop_d = tx_frame_nop_q;
        max_rcv_gap_d  = max_rcv_gap_q;
        max_bytes_d    = max_bytes_q;
        int_en_d       = int_en_q;
        w1c            = '0;
        cnt_clr        = {N_CNT{soft_rst}};
        sat_hit        = 1'b0;

        if (sel) begin
            case (reg_idx)
                REG_CTRL: begin
                    if (we[0]) power_down_d     = wdata[0];
                    if (we[1]) mode_d           = wdata[11:8];
                    if (we[2]) clk_div_d[7:0]   = wdata[23:16];
                    if (we[3]) clk_div_d[15:8]  = wdata[31:24];
                end
                REG_NOP: begin
                    if (we[0]) tx_byte_nop_d[7:0]   = wdata[7:0];
                    if (we[1]) tx_byte_nop_d[15:8]  = wdata[15:8];
                    if (we[2]) tx_frame_nop_d[7:0]  = wdata[23:16];
                    if (we[3]) tx_frame_nop_d[15:8] = wdata[31:24];
                end
                REG_GAP: begin
                    if (we[0]) max_rcv_gap_d[7:0]  = wdata[7:0];
                    if (we[1]) max_rcv_gap_d[15:8] = wdata[15:8];
                end
                REG_MAXB: begin
                    if (we[0]) max_bytes_d[7:0]   = wdata[7:0];
                    if (we[1]) max_bytes_d[15:8]  = wdata[15:8];
                    if (we[2]) max_bytes_d[23:16] = wdata[23:16];
                end
                REG_INT_STAT: if (we[0]) w1c      = wdata[INT_W-1:0];
                REG_INT_EN:   if (we[0]) int_en_d = wdata[INT_W-1:0];
                REG_CNT_CLR:  if (we[0]) cnt_clr  = cnt_clr | wdata[N_CNT-1:0];
                default: ;
            endcase
        end

        // A clear suppresses the increment, so it can never produce a saturation event.
        for (int i = 0; i < N_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] && (cnt_q[i] != CNT_SAT)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
                if (cnt_q[i] == CNT_SAT_M1) sat_hit = 1'b1;
            end
        end

        int_stat_d = (int_stat_q & ~w1c) | {sat_hit, cnt_inc};
        irq_d      = |(int_stat_q & int_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_down_q   <= 1'b0;
            mode_q         <= '0;
            clk_div_q      <= DIV_RST;
            tx_byte_nop_q  <= '0;
            tx_frame_nop_q <= '0;
            max_rcv_gap_q  <= '0;
            max_bytes_q    <= '0;
            int_stat_q     <= '0;
            int_en_q       <= '0;
            irq_q          <= 1'b0;
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= '0;
        end else begin
            power_down_q   <= power_down_d;
            mode_q         <= mode_d;
            clk_div_q      <= clk_div_d;
            tx_byte_nop_q  <= tx_byte_nop_d;
            tx_frame_nop_q <= tx_frame_nop_d;
            max_rcv_gap_q  <= max_rcv_gap_d;
            max_bytes_q    <= max_bytes_d;
            int_stat_q     <= int_stat_d;
            int_en_q       <= int_en_d;
            irq_q          <= irq_d;
            for (int i = 0; i < N_CNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        case (reg_idx)
            REG_CTRL:      rdata = {clk_div_q, 4'h0, mode_q, 6'h0, soft_rst, power_down_q};
            REG_NOP:       rdata = {tx_frame_nop_q, tx_byte_nop_q};
            REG_GAP:       rdata = {16'h0, max_rcv_gap_q};
            REG_MAXB:      rdata = {8'h0, max_bytes_q};
            REG_TX_BYTES:  rdata = 32'(cnt_q[0]);
            REG_RX_BYTES:  rdata = 32'(cnt_q[1]);
            REG_RX_ERR:    rdata = 32'(cnt_q[2]);
            REG_START_ERR: rdata = 32'(cnt_q[3]);
            REG_INT_STAT:  rdata = 32'(int_stat_q);
            REG_INT_EN:    rdata = 32'(int_en_q);
            default:       rdata = '0;
        endcase
    end

    assign power_down   = power_down_q;
    assign mode         = mode_q;
    assign clk_div      = clk_div_q;
    assign tx_byte_nop  = tx_byte_nop_q;
    assign tx_frame_nop = tx_frame_nop_q;
    assign max_rcv_gap  = max_rcv_gap_q;
    assign max_bytes    = max_bytes_q;
    assign irq          = irq_q;

endmodule

// File: rtl/gj_axis_uart_regs_mc.sv
// Multi-channel UART register file on a BRAM-style port: decodes the channel
// field, fans the access out to per-channel blocks and registers the read data.
module gj_axis_uart_regs_mc
    import gj_uart_regs_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int DIV_RST  = 54253
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bram_en,
    input  logic [6:0]               bram_addr,
    input  logic [3:0]               bram_we,
    input  logic [31:0]              bram_wdata,
    output logic [31:0]              bram_rdata,
    output logic [CHANNELS-1:0]      powerDown,
    output logic [4*CHANNELS-1:0]    mode,
    output logic [16*CHANNELS-1:0]   clkDivX16,
    output logic [16*CHANNELS-1:0]   txByte_nop,
    output logic [16*CHANNELS-1:0]   txFrame_nop,
    output logic [16*CHANNELS-1:0]   maxRcvGap,
    output logic [24*CHANNELS-1:0]   maxBytesPerFrame,
    input  logic [CHANNELS-1:0]      softRst,
    input  logic [CHANNELS-1:0]      txBytesInt,
    input  logic [CHANNELS-1:0]      rxBytesInt,
    input  logic [CHANNELS-1:0]      rxBytesError,
    input  logic [CHANNELS-1:0]      startError,
    output logic [CHANNELS-1:0]      irq
);

    logic [CH_W-1:0]   acc_ch;
    logic [REG_W-1:0]  acc_reg;
    logic [DATA_W-1:0] chan_rdata [CHANNELS_MAX];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign acc_ch  = bram_addr[6:4];
    assign acc_reg = bram_addr[3:0];

    // Unpopulated channel slots read as zero and have nothing to write into.
    for (genvar gi = 0; gi < CHANNELS_MAX; gi++) begin : g_chan
        if (gi < CHANNELS) begin : g_on
            gj_uart_chan_regs #(
                .CNT_W   (CNT_W),
                .DIV_RST (DIV_W'(DIV_RST))
            ) u_chan (
                .clk            (clk),
                .rst_n          (rst_n),
                .sel            (bram_en && (acc_ch == CH_W'(gi))),
                .reg_idx        (acc_reg),
                .we             (bram_we),
                .wdata          (bram_wdata),
                .soft_rst       (softRst[gi]),
                .tx_bytes_int   (txBytesInt[gi]),
                .rx_bytes_int   (rxBytesInt[gi]),
                .rx_bytes_error (rxBytesError[gi]),
                .start_error    (startError[gi]),
                .power_down     (powerDown[gi]),
                .mode           (mode[MODE_W*gi +: MODE_W]),
                .clk_div        (clkDivX16[DIV_W*gi +: DIV_W]),
                .tx_byte_nop    (txByte_nop[NOP_W*gi +: NOP_W]),
                .tx_frame_nop   (txFrame_nop[NOP_W*gi +: NOP_W]),
                .max_rcv_gap    (maxRcvGap[GAP_W*gi +: GAP_W]),
                .max_bytes      (maxBytesPerFrame[MAXB_W*gi +: MAXB_W]),
                .rdata          (chan_rdata[gi]),
                .irq            (irq[gi])
            );
        end else begin : g_off
            assign chan_rdata[gi] = '0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bram_en) rdata_d = chan_rdata[acc_ch];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign bram_rdata = rdata_q;

endmodule
